// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared definitions for the fetch PC sequencer.
// Provides the flag_branch encodings, the sequencer FSM state type and
// the default first fetch address after reset.
package pc_seq_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FLAG_NONE   = 2'b00,
        FLAG_JAL    = 2'b01,
        FLAG_JALR   = 2'b10,
        FLAG_BRANCH = 2'b11
    } flag_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN,
        HALT
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle of all sequencer handshakes.
// Signals: redirect group (redirect_valid, flag_branch, pc_target,
// branch_taken), instruction memory req/ack (imem_req, imem_addr,
// imem_ack, imem_rdata), downstream valid/ready (instr_valid, instr,
// instr_pc, instr_ready) and status (flush, misalign_err).
// master = the sequencer, slave = its environment.
interface pc_sequencer_if;

    logic        redirect_valid;
    logic [1:0]  flag_branch;
    logic [31:0] pc_target;
    logic        branch_taken;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        flush;
    logic        misalign_err;

    modport master (
        input  redirect_valid, flag_branch, pc_target, branch_taken,
        input  imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        output flush, misalign_err
    );

    modport slave (
        output redirect_valid, flag_branch, pc_target, branch_taken,
        output imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  flush, misalign_err
    );

endinterface

// File: rtl/pc_sequencer_redirect_decode.sv
// redirect_decode: combinational redirect qualification.
// Inputs : redirect_valid_i, flag_i, pc_target_i, branch_taken_i
// Outputs: taken_o (redirect must be followed), target_o (effective
//          target), misaligned_o (taken with target[1:0] != 0)
// With PC_SEQ_MISALIGN_CHECK_EN undefined the target is word-aligned
// by force and misaligned_o is constant 0.
module redirect_decode
    import pc_seq_pkg::*;
(
    input  logic        redirect_valid_i,
    input  logic [1:0]  flag_i,
    input  logic [31:0] pc_target_i,
    input  logic        branch_taken_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    assign taken_o = redirect_valid_i & ((flag_i == FLAG_JAL) | (flag_i == FLAG_JALR) |
                                         ((flag_i == FLAG_BRANCH) & branch_taken_i));

`ifdef PC_SEQ_MISALIGN_CHECK_EN
    // JALR clears bit 0 of the target; any remaining low bits are an error
    assign target_o     = pc_target_i & ~{31'd0, flag_i == FLAG_JALR};
    assign misaligned_o = taken_o & (|target_o[1:0]);
`else
    assign target_o     = pc_target_i & ~32'h3;
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side program counter sequencer.
// Ports: clk, rst_n (async active-low), bus (pc_sequencer_if.master)
// carrying redirect inputs, imem req/ack, instr valid/ready, flush and
// misalign_err. All bus outputs are registered.
// Optional feature macro: PC_SEQ_MISALIGN_CHECK_EN (misaligned redirect
// targets set sticky misalign_err and halt fetch until reset).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    state_e      state_q;
    logic [31:0] addr_q, instr_q, pc_q, tgt_q;
    logic        req_q, valid_q, flush_q, err_q;
    logic        taken, mis;
    logic [31:0] target;

    redirect_decode u_dec (
        .redirect_valid_i (bus.redirect_valid),
        .flag_i           (bus.flag_branch),
        .pc_target_i      (bus.pc_target),
        .branch_taken_i   (bus.branch_taken),
        .taken_o          (taken),
        .target_o         (target),
        .misaligned_o     (mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            pc_q    <= '0;
            tgt_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= RESET_PC;
                end
                // FETCH and DRAIN share the outstanding request; err_q doubles as
                // "halt once the request completes" after a misaligned redirect.
                FETCH, DRAIN: begin
                    if (taken) begin
                        flush_q <= 1'b1;
                        tgt_q   <= target;
                        err_q   <= err_q | mis;
                    end
                    if (bus.imem_ack) begin
                        if (state_q == FETCH && !taken) begin
                            instr_q <= bus.imem_rdata;
                            pc_q    <= addr_q;
                            valid_q <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= HOLD;
                        end else if (err_q | mis) begin
                            req_q   <= 1'b0;
                            state_q <= HALT;
                        end else begin
                            addr_q  <= taken ? target : tgt_q;
                            state_q <= FETCH;
                        end
                    end else if (taken) begin
                        state_q <= DRAIN;
                    end
                end
                HOLD: begin
                    if (taken) begin
                        flush_q <= 1'b1;
                        valid_q <= 1'b0;
                        err_q   <= err_q | mis;
                        req_q   <= !mis;
                        addr_q  <= mis ? addr_q : target;
                        state_q <= mis ? HALT : FETCH;
                    end else if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q + 32'd4;
                        state_q <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = pc_q;
    assign bus.flush       = flush_q;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    assign bus.misalign_err = err_q;
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (directed vector
// table, hand-written corner sequences, random run against a model).
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_sequencer_if b ();
    pc_sequencer_if bw ();

    pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(b.master));
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw.master));

    typedef struct {
        logic        ack, rdy, rv;
        logic [1:0]  fl;
        logic        bt;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_flush;
    } vec_t;

    vec_t tv[23];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t v(input logic ack, rdy, rv, input logic [1:0] fl, input logic bt,
                               input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                               input logic e_val, input logic [31:0] e_pc, input logic e_flush);
        vec_t r;
        r.ack = ack; r.rdy = rdy; r.rv = rv; r.fl = fl; r.bt = bt; r.tgt = tgt;
        r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc; r.e_flush = e_flush;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ack, rdy, rv, input logic [1:0] fl, input logic bt,
                         input logic [31:0] tgt);
        b.imem_ack = ack; b.instr_ready = rdy; b.redirect_valid = rv;
        b.flag_branch = fl; b.branch_taken = bt; b.pc_target = tgt;
        b.imem_rdata = mem(b.imem_addr);
    endtask

    initial begin
        bw.imem_ack = 1'b1; bw.instr_ready = 1'b1; bw.redirect_valid = 1'b0;
        bw.flag_branch = 2'b00; bw.branch_taken = 1'b0; bw.pc_target = '0; bw.imem_rdata = '0;
    end

    initial begin
        logic        taken, prev_taken, prev_stall, ok;
        logic [31:0] exp_pc, eff, prev_addr, tgt;
        logic [1:0]  fl;
        int          delivered;

        //       ack rdy rv fl    bt tgt        | req addr        val pc          flush
        tv[0]  = v(0, 0, 0, 2'd0, 0, 0,          0, 32'h0,      0, 32'h0,      0);
        tv[1]  = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h0,      0, 0,          0);
        tv[2]  = v(0, 1, 0, 2'd0, 0, 0,          0, 0,          1, 32'h0,      0);
        tv[3]  = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h4,      0, 0,          0);
        tv[4]  = v(0, 1, 0, 2'd0, 0, 0,          0, 0,          1, 32'h4,      0);
        tv[5]  = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h8,      0, 0,          0);
        tv[6]  = v(0, 0, 1, 2'd1, 0, 32'h100,    0, 0,          1, 32'h8,      0);
        tv[7]  = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h100,    0, 0,          1);
        tv[8]  = v(0, 0, 1, 2'd3, 0, 32'h200,    0, 0,          1, 32'h100,    0);
        tv[9]  = v(0, 1, 0, 2'd0, 0, 0,          0, 0,          1, 32'h100,    0);
        tv[10] = v(0, 0, 1, 2'd3, 1, 32'h40,     1, 32'h104,    0, 0,          0);
        tv[11] = v(0, 0, 0, 2'd0, 0, 0,          1, 32'h104,    0, 0,          1);
        tv[12] = v(0, 0, 0, 2'd0, 0, 0,          1, 32'h104,    0, 0,          0);
        tv[13] = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h104,    0, 0,          0);
        tv[14] = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h40,     0, 0,          0);
        tv[15] = v(0, 1, 0, 2'd0, 0, 0,          0, 0,          1, 32'h40,     0);
        tv[16] = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h44,     0, 0,          0);
        tv[17] = v(0, 1, 0, 2'd0, 0, 0,          0, 0,          1, 32'h44,     0);
        tv[18] = v(1, 0, 1, 2'd1, 0, 32'h300,    1, 32'h48,     0, 0,          0);
        tv[19] = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h300,    0, 0,          1);
        tv[20] = v(0, 1, 1, 2'd1, 0, 32'h80,     0, 0,          1, 32'h300,    0);
        tv[21] = v(0, 0, 0, 2'd0, 0, 0,          1, 32'h80,     0, 0,          1);
        tv[22] = v(1, 0, 0, 2'd0, 0, 0,          1, 32'h80,     0, 0,          0);

        drive(0, 0, 0, 2'd0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, b.imem_req}, 0);
        chk("rst_instr", b.instr, 0);
        chk("rst_misalign", {31'd0, b.misalign_err}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, b.imem_req}, {31'd0, tv[i].e_req});
            chk($sformatf("v%0d_valid", i), {31'd0, b.instr_valid}, {31'd0, tv[i].e_val});
            chk($sformatf("v%0d_flush", i), {31'd0, b.flush}, {31'd0, tv[i].e_flush});
            if (tv[i].e_req) chk($sformatf("v%0d_addr", i), b.imem_addr, tv[i].e_addr);
            if (tv[i].e_val) begin
                chk($sformatf("v%0d_pc", i), b.instr_pc, tv[i].e_pc);
                chk($sformatf("v%0d_instr", i), b.instr, mem(tv[i].e_pc));
            end
            if (i == 1) chk("wrap_first_addr", bw.imem_addr, 32'hFFFF_FFFC);
            if (i == 3) chk("wrap_second_addr", bw.imem_addr, 32'h0);
            if (i == 4) chk("wrap_second_pc", bw.instr_pc, 32'h0);
            drive(tv[i].ack, tv[i].rdy, tv[i].rv, tv[i].fl, tv[i].bt, tv[i].tgt);
        end

        // JALR to 0x203 from HOLD
        @(negedge clk);
        chk("jalr_hold_valid", {31'd0, b.instr_valid}, 1);
        chk("jalr_hold_pc", b.instr_pc, 32'h80);
        drive(0, 0, 1, 2'd2, 0, 32'h203);
        @(negedge clk);
        drive(0, 0, 0, 2'd0, 0, 0);
        chk("jalr_flush", {31'd0, b.flush}, 1);
        chk("jalr_valid", {31'd0, b.instr_valid}, 0);
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            chk("jalr_halt_req", {31'd0, b.imem_req}, 0);
            chk("jalr_misalign", {31'd0, b.misalign_err}, 1);
            @(negedge clk);
            drive(1, 1, 0, 2'd0, 0, 0);
        end
`else
        chk("jalr_req", {31'd0, b.imem_req}, 1);
        chk("jalr_addr", b.imem_addr, 32'h200);
        chk("jalr_misalign", {31'd0, b.misalign_err}, 0);
`endif

        // random run against a program-order model
        rst_n = 1'b0;
        drive(0, 0, 0, 2'd0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0; prev_taken = 1'b0; prev_stall = 1'b0; prev_addr = '0; delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c > 0) @(negedge clk);
            chk("rnd_flush", {31'd0, b.flush}, {31'd0, prev_taken});
            if (prev_taken) chk("rnd_flush_valid", {31'd0, b.instr_valid}, 0);
            if (prev_stall) begin
                chk("rnd_req_held", {31'd0, b.imem_req}, 1);
                chk("rnd_addr_held", b.imem_addr, prev_addr);
            end
            fl = 2'($urandom);
`ifdef PC_SEQ_MISALIGN_CHECK_EN
            tgt = {$urandom() & 32'hFFFF_FFFC} | {31'd0, fl == 2'd2 && $urandom_range(0, 1) == 1};
`else
            tgt = $urandom();
`endif
            drive(b.imem_req && $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                  c >= 1 && $urandom_range(0, 7) == 0, fl, $urandom_range(0, 1) == 1, tgt);
            taken = b.redirect_valid && (fl == 2'd1 || fl == 2'd2 || (fl == 2'd3 && b.branch_taken));
            eff = (fl == 2'd2) ? (tgt & ~32'h1) : tgt;
`ifndef PC_SEQ_MISALIGN_CHECK_EN
            eff = eff & ~32'h3;
`endif
            if (b.instr_valid && b.instr_ready) begin
                chk("rnd_pc", b.instr_pc, exp_pc);
                chk("rnd_instr", b.instr, mem(b.instr_pc));
                exp_pc = b.instr_pc + 32'd4;
                delivered++;
            end
            if (taken) exp_pc = eff;
            prev_taken = taken;
            prev_stall = b.imem_req && !b.imem_ack;
            prev_addr = b.imem_addr;
        end
        chk("rnd_progress", {31'd0, delivered >= 100}, 1);

        // reset in the middle of an outstanding request
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            drive(0, 1, 0, 2'd0, 0, 0);
            ok = b.imem_req;
        end
        chk("midrst_req_before", {31'd0, ok}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, b.imem_req}, 0);
        chk("midrst_addr", b.imem_addr, 32'h0);
        chk("midrst_valid", {31'd0, b.instr_valid}, 0);
        chk("midrst_flush", {31'd0, b.flush}, 0);
        chk("midrst_pc", b.instr_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
